// File: rtl/control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// control_fsm_pkg
//   Shared definitions for the multi-cycle integer-datapath controller:
//   FSM state codes, ALU op codes, major opcode constants, func7b50 classes,
//   MU op codes and the func3 -> ALU op helper used by the decoder.
//   No ports (package).
// -----------------------------------------------------------------------------
package control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        MU_MUL    = 2'd0,
        MU_MULH   = 2'd1,
        MU_MULHSU = 2'd2,
        MU_MULHU  = 2'd3
    } mu_op_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    // {instr[30], instr[25]} classes
    localparam logic [1:0] F7_BASE   = 2'b00;
    localparam logic [1:0] F7_ALT    = 2'b10;
    localparam logic [1:0] F7_MULDIV = 2'b01;

    // 'alt' selects the instr[30] variant (SUB / SRA) of func3 000 / 101.
    function automatic alu_op_t alu_from_func3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// -----------------------------------------------------------------------------
// control_fsm_alu_decoder
//   Combinational instruction classifier for the controller.
//   Optional feature macro: MULDIV_EN (R-type func7b50=01, func3[2]=0 -> MU op).
// Ports:
//   opcode   in  7  instr[6:0]
//   func3    in  3  instr[14:12]
//   func7b50 in  2  {instr[30], instr[25]}
//   aluctl   out 4  ALU op code
//   legal    out 1  encoding is supported
//   is_mu    out 1  instruction executes on the multiply unit
// -----------------------------------------------------------------------------
module control_fsm_alu_decoder
    import control_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [1:0] func7b50,
    output alu_op_t    aluctl,
    output logic       legal,
    output logic       is_mu
);

    always_comb begin
        aluctl = ALU_ADD;
        legal  = 1'b0;
        is_mu  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func7b50)
                    F7_BASE: begin
                        legal  = 1'b1;
                        aluctl = alu_from_func3(func3, 1'b0);
                    end
                    F7_ALT: begin
                        if (func3 == 3'b000 || func3 == 3'b101) begin
                            legal  = 1'b1;
                            aluctl = alu_from_func3(func3, 1'b1);
                        end
                    end
                    F7_MULDIV: begin
`ifdef MULDIV_EN
                        // Divide/remainder (func3[2]=1) has no unit behind it.
                        if (!func3[2]) begin
                            legal = 1'b1;
                            is_mu = 1'b1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
            OP_ITYPE: begin
                case (func3)
                    3'b001: begin
                        legal  = (func7b50 == F7_BASE);
                        aluctl = ALU_SLL;
                    end
                    3'b101: begin
                        if (func7b50 == F7_BASE) begin
                            legal  = 1'b1;
                            aluctl = ALU_SRL;
                        end else if (func7b50 == F7_ALT) begin
                            legal  = 1'b1;
                            aluctl = ALU_SRA;
                        end
                    end
                    // For the other I-type ops these bits are immediate bits.
                    default: begin
                        legal  = 1'b1;
                        aluctl = alu_from_func3(func3, 1'b0);
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//   Multi-cycle FETCH/DECODE/EXEC/WB controller for the integer datapath,
//   one instruction in flight. Waits on exdone for MU ops, flags unsupported
//   encodings (illegal) and MU timeouts (fault), counts retired instructions.
//   Optional feature macro: MULDIV_EN (enables MUL/MULH/MULHSU/MULHU).
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          synchronous active-low reset
//   opcode     in   7          instr[6:0]
//   func3      in   3          instr[14:12]
//   func7b50   in   2          {instr[30], instr[25]}
//   exdone     in   1          EX-stage valid from datapath
//   pcmuxctl   out  clog2(N)   pc source select (always pc+4)
//   pcnextctl  out  1          pc update strobe
//   instrre    out  1          instruction memory read enable
//   regre      out  1          regfile read enable
//   regwe      out  1          regfile write enable
//   bmuxctl    out  1          0=rs2, 1=sign-extended imm
//   aluctl     out  4          ALU op
//   mulstart   out  1          MU start pulse
//   mulctl     out  2          MU op
//   ifuresctl  out  clog2(N)   result select 0=ALU, 1=MU
//   illegal    out  1          sticky unsupported-instruction flag
//   fault      out  1          sticky MU-timeout flag
//   instret    out  INSTRET_W  retired-instruction count
// -----------------------------------------------------------------------------
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int PCMUX_N     = 2,
    parameter int IFURESCTL_N = 2,
    parameter int MU_TIMEOUT  = 64,
    parameter int INSTRET_W   = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     func3,
    input  logic [1:0]                     func7b50,
    input  logic                           exdone,
    output logic [$clog2(PCMUX_N)-1:0]     pcmuxctl,
    output logic                           pcnextctl,
    output logic                           instrre,
    output logic                           regre,
    output logic                           regwe,
    output logic                           bmuxctl,
    output logic [3:0]                     aluctl,
    output logic                           mulstart,
    output logic [1:0]                     mulctl,
    output logic [$clog2(IFURESCTL_N)-1:0] ifuresctl,
    output logic                           illegal,
    output logic                           fault,
    output logic [INSTRET_W-1:0]           instret
);

    localparam int IFW    = $clog2(IFURESCTL_N);
    localparam int WAIT_W = $clog2(MU_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MU_TIMEOUT - 1);

    alu_op_t dec_aluctl;
    logic    dec_legal;
    logic    dec_is_mu;

    control_fsm_alu_decoder u_dec (
        .opcode   (opcode),
        .func3    (func3),
        .func7b50 (func7b50),
        .aluctl   (dec_aluctl),
        .legal    (dec_legal),
        .is_mu    (dec_is_mu)
    );

    state_t                 state;
    logic                   instrre_q;
    logic                   regre_q;
    logic                   regwe_q;
    logic                   pcnext_q;
    logic                   bmux_q;
    logic [3:0]             aluctl_q;
    logic [IFW-1:0]         ifures_q;
    logic                   is_mu_q;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   illegal_q;
    logic                   fault_q;
    logic [INSTRET_W-1:0]   instret_q;
`ifdef MULDIV_EN
    logic                   mulstart_q;
    logic [1:0]             mulctl_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            instrre_q <= 1'b0;
            regre_q   <= 1'b0;
            regwe_q   <= 1'b0;
            pcnext_q  <= 1'b0;
            bmux_q    <= 1'b0;
            aluctl_q  <= '0;
            ifures_q  <= '0;
            is_mu_q   <= 1'b0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            instret_q <= '0;
`ifdef MULDIV_EN
            mulstart_q <= 1'b0;
            mulctl_q   <= '0;
`endif
        end else begin
            // Strobes are single-cycle unless the state below re-asserts them.
            instrre_q <= 1'b0;
            regre_q   <= 1'b0;
            regwe_q   <= 1'b0;
            pcnext_q  <= 1'b0;
`ifdef MULDIV_EN
            mulstart_q <= 1'b0;
`endif
            case (state)
                ST_FETCH: begin
                    // Out of reset the outputs are all 0, so the first FETCH
                    // cycle only raises instrre; the read happens the next one.
                    if (!instrre_q) begin
                        instrre_q <= 1'b1;
                    end else begin
                        state   <= ST_DECODE;
                        regre_q <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (dec_legal) begin
                        state    <= ST_EXEC;
                        aluctl_q <= dec_aluctl;
                        bmux_q   <= (opcode == OP_ITYPE);
                        ifures_q <= IFW'(dec_is_mu);
                        is_mu_q  <= dec_is_mu;
                        wait_cnt <= '0;
`ifdef MULDIV_EN
                        mulstart_q <= dec_is_mu;
                        mulctl_q   <= mu_op_t'(func3[1:0]);
`endif
                    end else begin
                        state     <= ST_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // exdone in the first MU cycle may be left over from the
                    // previous op, so it only counts once wait_cnt has moved.
                    if (!is_mu_q || (wait_cnt != '0 && exdone)) begin
                        state    <= ST_WB;
                        regwe_q  <= 1'b1;
                        pcnext_q <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ST_HALT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    state     <= ST_FETCH;
                    instrre_q <= 1'b1;
                    instret_q <= instret_q + INSTRET_W'(1);
                end
                default: begin
                    // HALT: strobes stay low, controls hold until reset.
                    state <= ST_HALT;
                end
            endcase
        end
    end

    assign pcmuxctl  = '0;
    assign pcnextctl = pcnext_q;
    assign instrre   = instrre_q;
    // regre goes out only once the fetched word is known to be legal.
    assign regre     = regre_q & dec_legal;
    assign regwe     = regwe_q;
    assign bmuxctl   = bmux_q;
    assign aluctl    = aluctl_q;
    assign ifuresctl = ifures_q;
    assign illegal   = illegal_q;
    assign fault     = fault_q;
    assign instret   = instret_q;
`ifdef MULDIV_EN
    assign mulstart  = mulstart_q;
    assign mulctl    = mulctl_q;
`else
    assign mulstart  = 1'b0;
    assign mulctl    = 2'b00;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm
//   Directed self-checking bench for control_fsm. MU-dependent scenarios are
//   selected by the MULDIV_EN macro, matching the RTL build.
// -----------------------------------------------------------------------------
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [1:0]  func7b50;
    logic        exdone;
    logic [0:0]  pcmuxctl;
    logic        pcnextctl;
    logic        instrre;
    logic        regre;
    logic        regwe;
    logic        bmuxctl;
    logic [3:0]  aluctl;
    logic        mulstart;
    logic [1:0]  mulctl;
    logic [0:0]  ifuresctl;
    logic        illegal;
    logic        fault;
    logic [31:0] instret;

    int n_chk = 0;
    int n_err = 0;

    control_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .func3     (func3),
        .func7b50  (func7b50),
        .exdone    (exdone),
        .pcmuxctl  (pcmuxctl),
        .pcnextctl (pcnextctl),
        .instrre   (instrre),
        .regre     (regre),
        .regwe     (regwe),
        .bmuxctl   (bmuxctl),
        .aluctl    (aluctl),
        .mulstart  (mulstart),
        .mulctl    (mulctl),
        .ifuresctl (ifuresctl),
        .illegal   (illegal),
        .fault     (fault),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7);
        opcode   = op;
        func3    = f3;
        func7b50 = f7;
    endtask

    // Reset, release, and land in the first FETCH cycle with instrre=1.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check("rst_regwe", regwe, 0);
        check("rst_instret", instret, 0);
        rst_n = 1'b1;
        tick();
        check("rst_fetch_instrre", instrre, 1);
    endtask

    // Starts in a FETCH cycle (instrre=1); ends in the next FETCH cycle.
    task automatic run_alu(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [1:0] f7, input logic [3:0] exp_alu, input logic exp_bmux);
        set_instr(op, f3, f7);
        tick();
        check({nm, "_regre"}, regre, 1);
        check({nm, "_instrre_off"}, instrre, 0);
        tick();
        check({nm, "_aluctl"}, aluctl, exp_alu);
        check({nm, "_bmux"}, bmuxctl, exp_bmux);
        check({nm, "_ifures"}, ifuresctl, 0);
        check({nm, "_exec_regwe"}, regwe, 0);
        tick();
        check({nm, "_wb_regwe"}, regwe, 1);
        check({nm, "_wb_pcnext"}, pcnextctl, 1);
        tick();
        check({nm, "_fetch_instrre"}, instrre, 1);
        check({nm, "_fetch_regwe"}, regwe, 0);
    endtask

    // From a FETCH cycle, decode an unsupported word and confirm HALT.
    task automatic run_illegal(input string nm, input logic [6:0] op, input logic [2:0] f3,
                               input logic [1:0] f7);
        int we_seen;
        set_instr(op, f3, f7);
        tick();
        check({nm, "_regre"}, regre, 0);
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (regwe || pcnextctl || instrre) we_seen++;
        end
        check({nm, "_illegal"}, illegal, 1);
        check({nm, "_no_strobes"}, we_seen, 0);
        check({nm, "_mulstart"}, mulstart, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        exdone = 1'b0;
        set_instr(7'b0110011, 3'b000, 2'b00);
        tick();
        tick();
        check("reset_instrre", instrre, 0);
        check("reset_regwe", regwe, 0);
        check("reset_pcnext", pcnextctl, 0);
        check("reset_pcmux", pcmuxctl, 0);
        check("reset_instret", instret, 0);
        check("reset_illegal", illegal, 0);
        check("reset_fault", fault, 0);
        check("reset_mulstart", mulstart, 0);
        rst_n = 1'b1;
        tick();
        check("c0_instrre", instrre, 1);

        run_alu("add", 7'b0110011, 3'b000, 2'b00, 4'd0, 1'b0);
        check("add_instret", instret, 1);

        // ADDI then SRAI from reset: two retirements in eight cycles.
        do_reset();
        run_alu("addi", 7'b0010011, 3'b000, 2'b00, 4'd0, 1'b1);
        run_alu("srai", 7'b0010011, 3'b101, 2'b10, 4'd7, 1'b1);
        check("addi_srai_instret", instret, 2);

        run_alu("sub",   7'b0110011, 3'b000, 2'b10, 4'd1, 1'b0);
        run_alu("and",   7'b0110011, 3'b111, 2'b00, 4'd9, 1'b0);
        run_alu("xor",   7'b0110011, 3'b100, 2'b00, 4'd5, 1'b0);
        run_alu("srli",  7'b0010011, 3'b101, 2'b00, 4'd6, 1'b1);
        run_alu("sltiu", 7'b0010011, 3'b011, 2'b11, 4'd4, 1'b1);
        check("alu_mix_instret", instret, 7);

        run_illegal("branch", 7'b1100011, 3'b000, 2'b00);
        do_reset();
        check("illegal_cleared", illegal, 0);
        run_illegal("slli_bad", 7'b0010011, 3'b001, 2'b10);
        do_reset();
        run_illegal("sub_bad_f3", 7'b0110011, 3'b001, 2'b10);
        do_reset();
        run_illegal("div", 7'b0110011, 3'b100, 2'b01);

`ifdef MULDIV_EN
        begin
            int we_cnt;
            do_reset();
            // Stale exdone held high into the first EXEC cycle.
            set_instr(7'b0110011, 3'b000, 2'b01);
            exdone = 1'b1;
            tick();
            check("mul_regre", regre, 1);
            tick();
            check("mul_e0_mulstart", mulstart, 1);
            check("mul_e0_ifures", ifuresctl, 1);
            check("mul_e0_mulctl", mulctl, 0);
            tick();
            exdone = 1'b0;
            check("mul_e1_mulstart", mulstart, 0);
            check("mul_stale_ignored", regwe, 0);
            we_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (regwe) we_cnt++;
            end
            check("mul_wait_regwe", we_cnt, 0);
            exdone = 1'b1;
            tick();
            exdone = 1'b0;
            check("mul_wb_regwe", regwe, 1);
            check("mul_wb_ifures", ifuresctl, 1);
            tick();
            check("mul_fetch_regwe", regwe, 0);
            check("mul_instret", instret, 1);

            // MULHU: mulctl follows func3[1:0].
            set_instr(7'b0110011, 3'b011, 2'b01);
            tick();
            tick();
            check("mulhu_mulctl", mulctl, 3);
            exdone = 1'b1;
            tick();
            tick();
            exdone = 1'b0;
            check("mulhu_wb_regwe", regwe, 1);
            tick();
            check("mulhu_instret", instret, 2);

            // Timeout: exdone never arrives.
            do_reset();
            set_instr(7'b0110011, 3'b001, 2'b01);
            tick();
            tick();
            we_cnt = 0;
            for (int i = 0; i < 63; i++) begin
                tick();
                if (regwe || pcnextctl) we_cnt++;
            end
            check("to_fault_before", fault, 0);
            tick();
            check("to_fault", fault, 1);
            check("to_no_wb", we_cnt, 0);
            for (int i = 0; i < 3; i++) tick();
            check("to_halt_instrre", instrre, 0);
            check("to_halt_regwe", regwe, 0);
            check("to_fault_sticky", fault, 1);
            check("to_instret", instret, 0);

            // Reset in the middle of a MU op after one retirement.
            do_reset();
            run_alu("pre_add", 7'b0110011, 3'b000, 2'b00, 4'd0, 1'b0);
            set_instr(7'b0110011, 3'b000, 2'b01);
            tick();
            tick();
            tick();
            rst_n = 1'b0;
            tick();
            check("mid_rst_regwe", regwe, 0);
            check("mid_rst_pcnext", pcnextctl, 0);
            check("mid_rst_instrre", instrre, 0);
            check("mid_rst_ifures", ifuresctl, 0);
            check("mid_rst_instret", instret, 0);
            rst_n = 1'b1;
            tick();
            check("mid_rst_fetch", instrre, 1);
        end
`else
        do_reset();
        run_illegal("mul_no_mu", 7'b0110011, 3'b000, 2'b01);
        check("mul_no_mu_mulctl", mulctl, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
